// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gate-time frequency and period meter for divided clocks
module freq_meter #(
    parameter int SYS_CLK     = 50000000,
    parameter int GATE_CYCLES = 50000,
    parameter int CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             nreset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] period_cycles,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    // An instance built with an out-of-range window never leaves IDLE
    // instead of producing windows of the wrong length.
    localparam bit PARAMS_OK = (SYS_CLK > 0) && (GATE_CYCLES >= 2)
                             && ((longint'(GATE_CYCLES) >> CNT_W) == 0);

    state_t           state;
    state_t           state_next;
    logic             load_window;
    logic             gate_last;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             v1;
    logic             v2;
    logic             armed;
    logic             rise;

    logic [CNT_W-1:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] period_lat;
    logic             seen_rise;
    logic             ovf;

    logic [CNT_W-1:0] edge_cnt_next;
    logic [CNT_W-1:0] period_cnt_next;
    logic [CNT_W-1:0] period_lat_next;
    logic             seen_rise_next;
    logic             ovf_next;

    // Two-flop synchroniser plus history flop; v1/v2 mark when s1/s2 hold
    // real samples so a level that is already high at reset release is not
    // mistaken for a rise until the input has been seen low.
    always_ff @(posedge clk_in or negedge nreset) begin
        if (!nreset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= sig_in;
            s2    <= s1;
            s3    <= s2;
            v1    <= 1'b1;
            v2    <= v1;
            armed <= armed | (v2 & ~s2);
        end
    end

    assign rise      = s2 & ~s3 & armed;
    assign gate_last = (gate_cnt == GATE_LAST);

    // Per-cycle update of the window counters, including a rise in the
    // current cycle, so the last window cycle can publish these values.
    always_comb begin
        edge_cnt_next   = edge_cnt;
        period_cnt_next = period_cnt;
        period_lat_next = period_lat;
        seen_rise_next  = seen_rise;
        ovf_next        = ovf;
        if (rise) begin
            if (edge_cnt != CNT_MAX) begin
                edge_cnt_next = edge_cnt + 1'b1;
            end
            period_cnt_next = '0;
            seen_rise_next  = 1'b1;
            if (seen_rise) begin
                period_lat_next = (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + 1'b1;
            end
        end else if (period_cnt != CNT_MAX) begin
            period_cnt_next = period_cnt + 1'b1;
        end
        if ((edge_cnt_next == CNT_MAX) || (period_cnt_next == CNT_MAX)) begin
            ovf_next = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load_window marks every entry into GATE.
    always_comb begin
        state_next  = state;
        load_window = 1'b0;
        case (state)
            IDLE: begin
                if (start && PARAMS_OK) begin
                    state_next  = GATE;
                    load_window = 1'b1;
                end
            end
            GATE: begin
                if (gate_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_next  = GATE;
                    load_window = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state == GATE) || (state == DONE);
    assign valid = (state == DONE);

    // Window counters: cleared on entry to GATE, advanced only inside GATE,
    // so rises seen in IDLE or DONE never reach a result.
    always_ff @(posedge clk_in or negedge nreset) begin
        if (!nreset) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            period_cnt <= '0;
            period_lat <= '0;
            seen_rise  <= 1'b0;
            ovf        <= 1'b0;
        end else if (load_window) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            period_cnt <= '0;
            period_lat <= '0;
            seen_rise  <= 1'b0;
            ovf        <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt   <= gate_cnt + 1'b1;
            edge_cnt   <= edge_cnt_next;
            period_cnt <= period_cnt_next;
            period_lat <= period_lat_next;
            seen_rise  <= seen_rise_next;
            ovf        <= ovf_next;
        end
    end

    // Result registers change only on the edge that closes a window.
    always_ff @(posedge clk_in or negedge nreset) begin
        if (!nreset) begin
            edge_count    <= '0;
            period_cycles <= '0;
            overflow      <= 1'b0;
        end else if ((state == GATE) && gate_last) begin
            edge_count    <= edge_cnt_next;
            period_cycles <= period_lat_next;
            overflow      <= ovf_next;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;

    logic        clk    = 1'b0;
    logic        nreset = 1'b0;

    logic        sig_a   = 1'b0;
    logic        start_a = 1'b0;
    logic        cont_a  = 1'b0;
    logic        busy_a;
    logic        valid_a;
    logic [31:0] edge_a;
    logic [31:0] per_a;
    logic        ovf_a;

    logic        sig_b   = 1'b0;
    logic        start_b = 1'b0;
    logic        cont_b  = 1'b0;
    logic        busy_b;
    logic        valid_b;
    logic [3:0]  edge_b;
    logic [3:0]  per_b;
    logic        ovf_b;

    int nchk  = 0;
    int nfail = 0;

    int   half_a = 0;
    int   ph_a   = 0;
    logic lvl_a  = 1'b0;

    freq_meter #(.SYS_CLK(100000000), .GATE_CYCLES(100), .CNT_W(32)) ua (
        .clk_in(clk), .nreset(nreset), .sig_in(sig_a), .start(start_a),
        .continuous(cont_a), .busy(busy_a), .valid(valid_a),
        .edge_count(edge_a), .period_cycles(per_a), .overflow(ovf_a)
    );

    freq_meter #(.SYS_CLK(100000000), .GATE_CYCLES(15), .CNT_W(4)) ub (
        .clk_in(clk), .nreset(nreset), .sig_in(sig_b), .start(start_b),
        .continuous(cont_b), .busy(busy_b), .valid(valid_b),
        .edge_count(edge_b), .period_cycles(per_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // sig_a is a square wave with half period half_a, or the level lvl_a when half_a is 0
    always @(negedge clk) begin
        if (half_a == 0) begin
            sig_a = lvl_a;
            ph_a  = 0;
        end else begin
            ph_a++;
            if (ph_a >= half_a) begin
                ph_a  = 0;
                sig_a = ~sig_a;
            end
        end
    end

    task automatic run_a(input int ncyc, input int rise_at, input int restart_at, input int reset_at,
                         output int first_valid, output int n_valid, output int n_busy);
        first_valid = 0;
        n_valid     = 0;
        n_busy      = 0;
        start_a     = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (busy_a) n_busy++;
            if (valid_a) begin
                n_valid++;
                if (first_valid == 0) first_valid = i;
            end
            start_a = (i == restart_at);
            if (i == rise_at) lvl_a = 1'b1;
            if (i == reset_at) nreset = 1'b0;
            if (i == reset_at + 3) nreset = 1'b1;
        end
    endtask

    task automatic run_b(input int ncyc, input int rise_at, output int first_valid, output int n_valid);
        first_valid = 0;
        n_valid     = 0;
        start_b     = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (valid_b) begin
                n_valid++;
                if (first_valid == 0) first_valid = i;
            end
            start_b = 1'b0;
            if (i == rise_at) sig_b = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nchk++; if (busy_a !== 1'b0)  begin nfail++; $display("FAIL reset_busy_a: got %0d expected 0", busy_a); end
        nchk++; if (valid_a !== 1'b0) begin nfail++; $display("FAIL reset_valid_a: got %0d expected 0", valid_a); end
        nchk++; if (edge_a !== 32'd0) begin nfail++; $display("FAIL reset_edge_a: got %0d expected 0", edge_a); end
        nchk++; if (per_a !== 32'd0)  begin nfail++; $display("FAIL reset_per_a: got %0d expected 0", per_a); end
        nchk++; if (ovf_a !== 1'b0)   begin nfail++; $display("FAIL reset_ovf_a: got %0d expected 0", ovf_a); end
        nchk++; if (busy_b !== 1'b0)  begin nfail++; $display("FAIL reset_busy_b: got %0d expected 0", busy_b); end
        nchk++; if (ovf_b !== 1'b0)   begin nfail++; $display("FAIL reset_ovf_b: got %0d expected 0", ovf_b); end
        nreset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        int fv, nv, nb;
        half_a = 2;
        repeat (20) @(negedge clk);
        run_a(130, 0, 0, 0, fv, nv, nb);
        nchk++; if (fv !== 101)       begin nfail++; $display("FAIL basic_latency: got %0d expected 101", fv); end
        nchk++; if (nv !== 1)         begin nfail++; $display("FAIL basic_nvalid: got %0d expected 1", nv); end
        nchk++; if (nb !== 101)       begin nfail++; $display("FAIL basic_busy_len: got %0d expected 101", nb); end
        nchk++; if (edge_a !== 32'd25) begin nfail++; $display("FAIL basic_edges: got %0d expected 25", edge_a); end
        nchk++; if (per_a !== 32'd4)  begin nfail++; $display("FAIL basic_period: got %0d expected 4", per_a); end
        nchk++; if (ovf_a !== 1'b0)   begin nfail++; $display("FAIL basic_ovf: got %0d expected 0", ovf_a); end
        nchk++; if (busy_a !== 1'b0)  begin nfail++; $display("FAIL basic_idle: got %0d expected 0", busy_a); end
    endtask

    task automatic test_static();
        int fv, nv, nb;
        half_a = 0;
        lvl_a  = 1'b0;
        repeat (10) @(negedge clk);
        lvl_a = 1'b1;
        repeat (10) @(negedge clk);
        run_a(130, 0, 0, 0, fv, nv, nb);
        nchk++; if (fv !== 101)       begin nfail++; $display("FAIL static_latency: got %0d expected 101", fv); end
        nchk++; if (nv !== 1)         begin nfail++; $display("FAIL static_valid_width: got %0d expected 1", nv); end
        nchk++; if (edge_a !== 32'd0) begin nfail++; $display("FAIL static_edges: got %0d expected 0", edge_a); end
        nchk++; if (per_a !== 32'd0)  begin nfail++; $display("FAIL static_period: got %0d expected 0", per_a); end
    endtask

    task automatic test_single_rise();
        int fv, nv, nb;
        half_a = 0;
        lvl_a  = 1'b0;
        repeat (10) @(negedge clk);
        run_a(130, 50, 0, 0, fv, nv, nb);
        nchk++; if (nv !== 1)         begin nfail++; $display("FAIL single_nvalid: got %0d expected 1", nv); end
        nchk++; if (edge_a !== 32'd1) begin nfail++; $display("FAIL single_edges: got %0d expected 1", edge_a); end
        nchk++; if (per_a !== 32'd0)  begin nfail++; $display("FAIL single_period: got %0d expected 0", per_a); end
    endtask

    task automatic test_continuous();
        int n_valid = 0;
        int last    = 0;
        half_a = 5;
        cont_a = 1'b1;
        repeat (20) @(negedge clk);
        start_a = 1'b1;
        for (int i = 1; i <= 520; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (valid_a) begin
                n_valid++;
                nchk++; if (edge_a !== 32'd10) begin nfail++; $display("FAIL cont_edges: got %0d expected 10 at cycle %0d", edge_a, i); end
                nchk++; if (per_a !== 32'd10)  begin nfail++; $display("FAIL cont_period: got %0d expected 10 at cycle %0d", per_a, i); end
                nchk++; if (i - last !== 101)  begin nfail++; $display("FAIL cont_interval: got %0d expected 101", i - last); end
                last = i;
            end
            if (i == 330) cont_a = 1'b0;
        end
        nchk++; if (n_valid !== 4)   begin nfail++; $display("FAIL cont_nvalid: got %0d expected 4", n_valid); end
        nchk++; if (last !== 404)    begin nfail++; $display("FAIL cont_last_valid: got %0d expected 404", last); end
        nchk++; if (busy_a !== 1'b0) begin nfail++; $display("FAIL cont_idle: got %0d expected 0", busy_a); end
    endtask

    task automatic test_reset_abort();
        int fv, nv, nb;
        half_a = 2;
        run_a(200, 0, 0, 50, fv, nv, nb);
        nchk++; if (nv !== 0)         begin nfail++; $display("FAIL abort_nvalid: got %0d expected 0", nv); end
        nchk++; if (nb !== 50)        begin nfail++; $display("FAIL abort_busy_len: got %0d expected 50", nb); end
        nchk++; if (edge_a !== 32'd0) begin nfail++; $display("FAIL abort_edges: got %0d expected 0", edge_a); end
        nchk++; if (per_a !== 32'd0)  begin nfail++; $display("FAIL abort_period: got %0d expected 0", per_a); end
        nchk++; if (ovf_a !== 1'b0)   begin nfail++; $display("FAIL abort_ovf: got %0d expected 0", ovf_a); end
        nchk++; if (busy_a !== 1'b0)  begin nfail++; $display("FAIL abort_idle: got %0d expected 0", busy_a); end
    endtask

    task automatic test_reset_release_high();
        int fv, nv, nb;
        half_a = 0;
        lvl_a  = 1'b1;
        repeat (10) @(negedge clk);
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        run_a(130, 0, 0, 0, fv, nv, nb);
        nchk++; if (fv !== 101)       begin nfail++; $display("FAIL release_latency: got %0d expected 101", fv); end
        nchk++; if (edge_a !== 32'd0) begin nfail++; $display("FAIL release_high_edges: got %0d expected 0", edge_a); end
    endtask

    task automatic test_back_to_back();
        int fv, nv, nb;
        half_a = 2;
        repeat (20) @(negedge clk);
        run_a(250, 0, 30, 0, fv, nv, nb);
        nchk++; if (fv !== 101)        begin nfail++; $display("FAIL b2b_latency: got %0d expected 101", fv); end
        nchk++; if (nv !== 1)          begin nfail++; $display("FAIL b2b_nvalid: got %0d expected 1", nv); end
        nchk++; if (nb !== 101)        begin nfail++; $display("FAIL b2b_busy_len: got %0d expected 101", nb); end
        nchk++; if (edge_a !== 32'd25) begin nfail++; $display("FAIL b2b_edges: got %0d expected 25", edge_a); end
        nchk++; if (per_a !== 32'd4)   begin nfail++; $display("FAIL b2b_period: got %0d expected 4", per_a); end
    endtask

    task automatic test_saturation();
        int fv, nv;
        sig_b = 1'b0;
        repeat (10) @(negedge clk);
        run_b(40, 0, fv, nv);
        nchk++; if (fv !== 16)       begin nfail++; $display("FAIL sat_latency: got %0d expected 16", fv); end
        nchk++; if (nv !== 1)        begin nfail++; $display("FAIL sat_nvalid: got %0d expected 1", nv); end
        nchk++; if (ovf_b !== 1'b1)  begin nfail++; $display("FAIL sat_ovf: got %0d expected 1", ovf_b); end
        nchk++; if (edge_b !== 4'd0) begin nfail++; $display("FAIL sat_edges: got %0d expected 0", edge_b); end
        nchk++; if (per_b !== 4'd0)  begin nfail++; $display("FAIL sat_period: got %0d expected 0", per_b); end
        run_b(40, 3, fv, nv);
        nchk++; if (nv !== 1)        begin nfail++; $display("FAIL one_rise_nvalid: got %0d expected 1", nv); end
        nchk++; if (edge_b !== 4'd1) begin nfail++; $display("FAIL one_rise_edges: got %0d expected 1", edge_b); end
        nchk++; if (per_b !== 4'd0)  begin nfail++; $display("FAIL one_rise_period: got %0d expected 0", per_b); end
        nchk++; if (ovf_b !== 1'b0)  begin nfail++; $display("FAIL one_rise_ovf: got %0d expected 0", ovf_b); end
        nchk++; if (busy_b !== 1'b0) begin nfail++; $display("FAIL sat_idle: got %0d expected 0", busy_b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_static();
        test_single_rise();
        test_continuous();
        test_reset_abort();
        test_reset_release_high();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
